// File: rtl/cbud_counter_n.sv
// cbud_counter_n: parametrised synchronous up/down counter with modulus,
// optional saturation, cascade carry in/out and a registered wrap pulse.
// Chain instances by feeding one stage's o_cao into the next stage's i_cai
// with i_en common to all stages; stage 0 has i_cai tied high.
module cbud_counter_n #(
    parameter int                 WIDTH      = 8,
    parameter longint             MODULUS    = 0,
    parameter logic [WIDTH-1:0]   PRESET_VAL = '1,
    parameter bit                 SATURATE   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cs,
    input  logic             i_sd,
    input  logic             i_ld,
    input  logic             i_en,
    input  logic             i_cai,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_cao,
    output logic             o_tcq
);

    // Highest count value; MODULUS=0 selects the full binary range.
    localparam logic [WIDTH-1:0] TOP  = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_tcq;

    logic             w_step;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_at_term;
    logic [WIDTH-1:0] w_d_clamp;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tcq_nxt;

    assign w_step    = i_en & i_cai;
    assign w_at_top  = (r_q == TOP);
    assign w_at_zero = (r_q == ZERO);
    // Terminal value follows the current direction, so a change of i_up
    // moves o_cao in the same cycle.
    assign w_at_term = i_up ? w_at_top : w_at_zero;
    // Loads beyond the wrap point are pulled back to TOP so Q never leaves range.
    assign w_d_clamp = (i_d > TOP) ? TOP : i_d;

    // Next-state selection: clear > preset > load > count; everything else holds.
    always_comb begin
        w_q_nxt   = r_q;
        w_tcq_nxt = 1'b0;
        if (i_cs) begin
            w_q_nxt = ZERO;
        end else if (i_sd) begin
            w_q_nxt = PRESET_VAL;
        end else if (i_ld) begin
            w_q_nxt = w_d_clamp;
        end else if (w_step) begin
            if (i_up) begin
                if (w_at_top) begin
                    w_q_nxt   = SATURATE ? TOP : ZERO;
                    w_tcq_nxt = ~SATURATE;
                end else begin
                    w_q_nxt = r_q + ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_q_nxt   = SATURATE ? ZERO : TOP;
                    w_tcq_nxt = ~SATURATE;
                end else begin
                    w_q_nxt = r_q - ONE;
                end
            end
        end
    end

    // State register; reset overrides every other control on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= ZERO;
            r_tcq <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_tcq <= w_tcq_nxt;
        end
    end

    assign o_q   = r_q;
    assign o_tcq = r_tcq;
    assign o_cao = w_step & w_at_term;

endmodule

// File: tb/tb_cbud_counter_n.sv
// Bench for cbud_counter_n: four configurations share the control inputs;
// each vector selects which instance is observed. CAO is checked before the
// edge, Q/TCQ expectations go through a scoreboard queue and are checked
// after the edge.
module tb_cbud_counter_n;

    logic       clk;
    logic       rst, cs, sd, ld, en, cai, up;
    logic [7:0] d;

    // instance A: 8-bit full range, wrapping
    logic [7:0] a_q;  logic a_cao, a_tcq;
    // instance B: 4-bit modulus 10, preset 7
    logic [3:0] b_q;  logic b_cao, b_tcq;
    // cascade: two BCD digits
    logic [3:0] c0_q, c1_q; logic c0_cao, c1_cao, c0_tcq, c1_tcq;
    // instance S: 4-bit full range, saturating
    logic [3:0] s_q;  logic s_cao, s_tcq;

    cbud_counter_n #(.WIDTH(8), .MODULUS(0), .PRESET_VAL(8'hFF), .SATURATE(1'b0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sd(sd), .i_ld(ld), .i_en(en),
        .i_cai(cai), .i_up(up), .i_d(d), .o_q(a_q), .o_cao(a_cao), .o_tcq(a_tcq));

    cbud_counter_n #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(4'd7), .SATURATE(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sd(sd), .i_ld(ld), .i_en(en),
        .i_cai(cai), .i_up(up), .i_d(d[3:0]), .o_q(b_q), .o_cao(b_cao), .o_tcq(b_tcq));

    cbud_counter_n #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(4'd0), .SATURATE(1'b0)) u_c0 (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sd(sd), .i_ld(ld), .i_en(en),
        .i_cai(1'b1), .i_up(up), .i_d(d[3:0]), .o_q(c0_q), .o_cao(c0_cao), .o_tcq(c0_tcq));

    cbud_counter_n #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(4'd0), .SATURATE(1'b0)) u_c1 (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sd(sd), .i_ld(ld), .i_en(en),
        .i_cai(c0_cao), .i_up(up), .i_d(d[3:0]), .o_q(c1_q), .o_cao(c1_cao), .o_tcq(c1_tcq));

    cbud_counter_n #(.WIDTH(4), .MODULUS(0), .PRESET_VAL(4'hF), .SATURATE(1'b1)) u_s (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sd(sd), .i_ld(ld), .i_en(en),
        .i_cai(cai), .i_up(up), .i_d(d[3:0]), .o_q(s_q), .o_cao(s_cao), .o_tcq(s_tcq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        string      tag;
        logic       rst, cs, sd, ld, en, cai, up;
        logic [7:0] d;
        logic [1:0] cao;
        logic [7:0] q;
        logic [1:0] tcq;
    } vec_t;

    typedef struct {
        int         sel;
        string      tag;
        logic [7:0] q;
        logic [1:0] tcq;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mkv(int sel, string tag, logic r, logic c, logic s, logic l,
                                 logic e, logic ci, logic u, logic [7:0] dd,
                                 logic [1:0] ecao, logic [7:0] eq, logic [1:0] etcq);
        vec_t v;
        v.sel = sel; v.tag = tag;
        v.rst = r; v.cs = c; v.sd = s; v.ld = l; v.en = e; v.cai = ci; v.up = u; v.d = dd;
        v.cao = ecao; v.q = eq; v.tcq = etcq;
        return v;
    endfunction

    task automatic observe(input int sel, output logic [7:0] q, output logic [1:0] cao,
                           output logic [1:0] tcq);
        case (sel)
            0:       begin q = a_q;            cao = {1'b0, a_cao};   tcq = {1'b0, a_tcq}; end
            1:       begin q = {4'd0, b_q};    cao = {1'b0, b_cao};   tcq = {1'b0, b_tcq}; end
            2:       begin q = {c1_q, c0_q};   cao = {c1_cao, c0_cao}; tcq = {c1_tcq, c0_tcq}; end
            default: begin q = {4'd0, s_q};    cao = {1'b0, s_cao};   tcq = {1'b0, s_tcq}; end
        endcase
    endtask

    // Drive one vector at the falling edge, check CAO before the rising edge,
    // then pop the scoreboard and check Q/TCQ just after it.
    task automatic apply(input vec_t v);
        logic [7:0] q;
        logic [1:0] cao, tcq;
        exp_t e;
        @(negedge clk);
        rst = v.rst; cs = v.cs; sd = v.sd; ld = v.ld;
        en = v.en; cai = v.cai; up = v.up; d = v.d;
        e.sel = v.sel; e.tag = v.tag; e.q = v.q; e.tcq = v.tcq;
        sb.push_back(e);
        #1;
        observe(v.sel, q, cao, tcq);
        n_vec++;
        if (cao !== v.cao) begin
            n_fail++;
            $display("FAIL %s cao: got %b want %b", v.tag, cao, v.cao);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        observe(e.sel, q, cao, tcq);
        n_vec++;
        if (q !== e.q || tcq !== e.tcq) begin
            n_fail++;
            $display("FAIL %s q/tcq: got %h/%b want %h/%b", e.tag, q, tcq, e.q, e.tcq);
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; sd = 1'b0; ld = 1'b0;
        en = 1'b0; cai = 1'b0; up = 1'b1; d = 8'd0;
        repeat (2) @(posedge clk);

        // reset state and CAO just after reset in both directions
        apply(mkv(0, "rst_up", 1,0,0,0, 1,1,1, 8'd0, 2'b00, 8'd0, 2'b00));
        apply(mkv(0, "rst_dn", 1,0,0,0, 1,1,0, 8'd0, 2'b01, 8'd0, 2'b00));

        // 8-bit full range: 256 up steps, wrap back to 0
        for (int i = 0; i < 256; i++)
            apply(mkv(0, "a_run", 0,0,0,0, 1,1,1, 8'd0, (i == 255) ? 2'b01 : 2'b00,
                      8'((i + 1) % 256), (i == 255) ? 2'b01 : 2'b00));

        // modulus 10 up run
        apply(mkv(1, "b_rst", 1,0,0,0, 0,0,1, 8'd0, 2'b00, 8'd0, 2'b00));
        for (int i = 0; i < 10; i++)
            apply(mkv(1, "b_run", 0,0,0,0, 1,1,1, 8'd0, (i == 9) ? 2'b01 : 2'b00,
                      8'((i + 1) % 10), (i == 9) ? 2'b01 : 2'b00));

        // two BCD digits 00..99 then 00
        apply(mkv(2, "c_rst", 1,0,0,0, 0,0,1, 8'd0, 2'b00, 8'h00, 2'b00));
        for (int i = 0; i < 100; i++) begin
            int lo, hi, n;
            lo = i % 10; hi = i / 10; n = (i + 1) % 100;
            apply(mkv(2, "c_run", 0,0,0,0, 1,0,1, 8'd0,
                      {(lo == 9 && hi == 9), (lo == 9)},
                      {4'(n / 10), 4'(n % 10)},
                      {(i == 99), (lo == 9)}));
        end

        // modulus 10: clamp, down wrap, direction change, hold, preset
        tbl.push_back(mkv(1, "b_rst2",   1,0,0,0, 0,0,1, 8'd0,  2'b00, 8'd0, 2'b00));
        tbl.push_back(mkv(1, "b_clamp",  0,0,0,1, 0,0,1, 8'd12, 2'b00, 8'd9, 2'b00));
        tbl.push_back(mkv(1, "b_upwrap", 0,0,0,0, 1,1,1, 8'd0,  2'b01, 8'd0, 2'b01));
        tbl.push_back(mkv(1, "b_dnwrap", 0,0,0,0, 1,1,0, 8'd0,  2'b01, 8'd9, 2'b01));
        tbl.push_back(mkv(1, "b_dn",     0,0,0,0, 1,1,0, 8'd0,  2'b00, 8'd8, 2'b00));
        tbl.push_back(mkv(1, "b_dirchg", 0,0,0,0, 1,1,1, 8'd0,  2'b00, 8'd9, 2'b00));
        tbl.push_back(mkv(1, "b_caioff", 0,0,0,0, 1,0,1, 8'd0,  2'b00, 8'd9, 2'b00));
        tbl.push_back(mkv(1, "b_preset", 0,0,1,0, 0,0,1, 8'd0,  2'b00, 8'd7, 2'b00));
        // priority
        tbl.push_back(mkv(1, "p_all",    1,1,1,1, 0,0,1, 8'd5,  2'b00, 8'd0, 2'b00));
        tbl.push_back(mkv(1, "p_sd",     0,0,1,0, 0,0,1, 8'd0,  2'b00, 8'd7, 2'b00));
        tbl.push_back(mkv(1, "p_cs",     0,1,1,1, 0,0,1, 8'd5,  2'b00, 8'd0, 2'b00));
        tbl.push_back(mkv(1, "p_sdld",   0,0,1,1, 0,0,1, 8'd5,  2'b00, 8'd7, 2'b00));
        tbl.push_back(mkv(1, "p_ldcnt",  0,0,0,1, 1,1,1, 8'd5,  2'b00, 8'd5, 2'b00));
        // saturating 4-bit
        tbl.push_back(mkv(3, "s_rst",    1,0,0,0, 0,0,1, 8'd0,  2'b00, 8'd0,  2'b00));
        tbl.push_back(mkv(3, "s_ld14",   0,0,0,1, 0,0,1, 8'd14, 2'b00, 8'd14, 2'b00));
        tbl.push_back(mkv(3, "s_up1",    0,0,0,0, 1,1,1, 8'd0,  2'b00, 8'd15, 2'b00));
        tbl.push_back(mkv(3, "s_up2",    0,0,0,0, 1,1,1, 8'd0,  2'b01, 8'd15, 2'b00));
        tbl.push_back(mkv(3, "s_up3",    0,0,0,0, 1,1,1, 8'd0,  2'b01, 8'd15, 2'b00));
        tbl.push_back(mkv(3, "s_ld1",    0,0,0,1, 0,0,1, 8'd1,  2'b00, 8'd1,  2'b00));
        tbl.push_back(mkv(3, "s_dn1",    0,0,0,0, 1,1,0, 8'd0,  2'b00, 8'd0,  2'b00));
        tbl.push_back(mkv(3, "s_dn2",    0,0,0,0, 1,1,0, 8'd0,  2'b01, 8'd0,  2'b00));
        tbl.push_back(mkv(3, "s_dn3",    0,0,0,0, 1,1,0, 8'd0,  2'b01, 8'd0,  2'b00));
        // hold / enable on 8-bit
        tbl.push_back(mkv(0, "h_rst",    1,0,0,0, 0,0,1, 8'd0,  2'b00, 8'd0,  2'b00));
        tbl.push_back(mkv(0, "h_ld37",   0,0,0,1, 0,0,1, 8'd37, 2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_en0",    0,0,0,0, 0,1,1, 8'd0,  2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_cai0",   0,0,0,0, 1,0,1, 8'd0,  2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_both0",  0,0,0,0, 0,0,1, 8'd0,  2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_en0b",   0,0,0,0, 0,1,0, 8'd0,  2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_cai0b",  0,0,0,0, 1,0,0, 8'd0,  2'b00, 8'd37, 2'b00));
        tbl.push_back(mkv(0, "h_resume", 0,0,0,0, 1,1,1, 8'd0,  2'b00, 8'd38, 2'b00));
        // wrap pulse lasts one cycle; down wrap; reset mid-count
        tbl.push_back(mkv(0, "w_ld255",  0,0,0,1, 0,0,1, 8'd255,2'b00, 8'd255,2'b00));
        tbl.push_back(mkv(0, "w_wrap",   0,0,0,0, 1,1,1, 8'd0,  2'b01, 8'd0,  2'b01));
        tbl.push_back(mkv(0, "w_tcqclr", 0,0,0,0, 0,1,1, 8'd0,  2'b00, 8'd0,  2'b00));
        tbl.push_back(mkv(0, "w_dnwrap", 0,0,0,0, 1,1,0, 8'd0,  2'b01, 8'd255,2'b01));
        tbl.push_back(mkv(0, "w_dn",     0,0,0,0, 1,1,0, 8'd0,  2'b00, 8'd254,2'b00));
        tbl.push_back(mkv(0, "r_mid",    1,0,0,1, 1,1,0, 8'd9,  2'b00, 8'd0,  2'b00));
        tbl.push_back(mkv(0, "r_cao",    1,0,0,0, 1,1,0, 8'd0,  2'b01, 8'd0,  2'b00));
        tbl.push_back(mkv(0, "r_resume", 0,0,0,0, 1,1,1, 8'd0,  2'b00, 8'd1,  2'b00));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: got %0d entries left want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
